// File: rtl/reg_write_demux.sv
// Write side of the general-purpose register bank: one-entry staging buffer
// with valid/ready handshake, address decode and a flat register bus for the read muxes.
module reg_write_demux #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   hold,
    output logic [NREG*DATA_W-1:0] regs_flat,
    output logic                   pend_valid,
    output logic [ADDR_W-1:0]      pend_addr,
    output logic [DATA_W-1:0]      pend_data,
    output logic                   commit_valid,
    output logic [ADDR_W-1:0]      commit_addr
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              commit_valid_q, commit_valid_d;
    logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
    logic              accept;
    logic              commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
        end else begin
            state_q        <= state_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            commit_valid_q <= commit_valid_d;
            commit_addr_q  <= commit_addr_d;
        end
    end

    // A full buffer can still accept when it drains at the same edge.
    always_comb begin
        state_d        = state_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        commit_valid_d = 1'b0;
        commit_addr_d  = commit_addr_q;
        wr_ready       = (state_q == ST_EMPTY) || !hold;
        accept         = wr_valid && wr_ready;
        commit         = (state_q == ST_FULL) && !hold;

        if (commit) begin
            commit_valid_d = 1'b1;
            commit_addr_d  = pend_addr_q;
        end

        if (accept) begin
            state_d     = ST_FULL;
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
        end else if (commit) begin
            state_d = ST_EMPTY;
        end
    end

    assign pend_valid   = (state_q == ST_FULL);
    assign pend_addr    = pend_addr_q;
    assign pend_data    = pend_data_q;
    assign commit_valid = commit_valid_q;
    assign commit_addr  = commit_addr_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                // Commits to address 0 still pulse commit_valid but store nothing.
                assign regs_flat[gi*DATA_W +: DATA_W] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] reg_q;
                logic              wr_en;

                assign wr_en = commit && (pend_addr_q == ADDR_W'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        reg_q <= '0;
                    end else if (wr_en) begin
                        reg_q <= pend_data_q;
                    end
                end

                assign regs_flat[gi*DATA_W +: DATA_W] = reg_q;
            end
        end
    endgenerate

endmodule

// File: doc/reg_write_demux.md
Name: reg_write_demux

Overview:
- Write side of the 32-entry, 32-bit general-purpose register bank. The 32:1 read-select muxes consume its outputs.
- Decodes a 5-bit destination address and commits write-back data into the one selected register through a single-entry staging buffer with a valid/ready handshake.
- Exposes every register on a flat bus for the read muxes. Exposes the pending staged write so the read side can bypass it.

Parameters:
- DATA_W, 32, width of each register and of write data.
- ADDR_W, 5, destination address width.
- NREG, 32, number of registers (equals 2**ADDR_W).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is an ordinary register.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  staging buffer can accept this cycle.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  data to write.
- hold  in  1  pipeline stall; blocks commit of the staged entry.
- regs_flat  out  NREG*DATA_W  register k on bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- pend_valid  out  1  staging buffer holds an uncommitted write.
- pend_addr  out  ADDR_W  address of the staged write.
- pend_data  out  DATA_W  data of the staged write.
- commit_valid  out  1  one-cycle pulse: a commit happened at the last edge.
- commit_addr  out  ADDR_W  address of the last commit.

Behaviour:
- Reset is asynchronous on rst_n low.
  - Clears all registers, pend_valid, pend_addr, pend_data, commit_valid and commit_addr to 0.
  - wr_ready reads 1 while held in reset; it is combinational from pend_valid=0.
  - Any staged write is dropped. Reset mid-transfer commits nothing.
- States, encoded by pend_valid: EMPTY (0) and FULL (1).
- wr_ready = !pend_valid | !hold (combinational). An accept occurs when wr_valid & wr_ready at a rising edge.
- Commit condition at a rising edge: pend_valid & !hold.
  - Register[pend_addr] <= pend_data, unless ZERO_REG=1 and pend_addr=0.
  - commit_valid <= 1 and commit_addr <= pend_addr, including the discarded addr-0 case.
  - At any edge with no commit, commit_valid <= 0.
- EMPTY -> FULL on accept. The staging buffer loads wr_addr and wr_data.
- FULL with commit and no accept -> EMPTY.
- FULL with commit and accept at the same edge: the old entry commits and the new entry loads. The state stays FULL.
- FULL with hold=1: no commit, no accept, all state is frozen.
- Latency: data accepted at edge N appears on regs_flat after edge N+1 if hold is low at N+1. Each cycle of hold adds one cycle.
- Sustained throughput is one write per cycle when hold=0.
- Back-to-back writes to the same address resolve in order: the later write is the final value.
- With ZERO_REG=1, regs_flat bits [DATA_W-1:0] are constant 0 at all times.
- regs_flat and pend_* are driven straight from flops. There is no combinational path from wr_* to regs_flat.
- wr_addr and wr_data are ignored when the request is not accepted.
- wr_valid during reset has no effect.

Test Plan:
1. Reset, then write addr 5 data 0xDEADBEEF with hold=0.
   - Required: pend_valid=1 after edge 1.
   - Required: regs_flat[191:160]=0xDEADBEEF, commit_valid=1 and commit_addr=5 after edge 2.
   - Required: all other registers remain 0.
2. Stream addr 1..31, data 0x100+addr, one per cycle, hold=0.
   - Required: wr_ready stays 1 throughout.
   - Required: each register equals 0x100+k one cycle after its accept.
   - Required: commit_valid stays high for 31 consecutive cycles.
3. Stage addr 7 data 0x1234, then assert hold for 3 cycles with wr_valid=1 (addr 8).
   - Required during hold: wr_ready=0, pend_addr=7, reg7 unchanged.
   - Required after hold drops: reg7=0x1234 commits, addr 8 is accepted at that same edge, and reg8 updates one edge later.
4. Write addr 0 data 0xFFFFFFFF with ZERO_REG=1.
   - Required: commit_valid pulses with commit_addr=0 and regs_flat[31:0] stays 0.
   - Repeat with ZERO_REG=0. Required: reg0=0xFFFFFFFF.
5. Write addr 3 with 0xA, then addr 3 with 0xB on consecutive cycles.
   - Required: reg3=0xA for one cycle, then 0xB.
6. Stage addr 9 data 0x55, drop rst_n mid-cycle before the commit edge, release it.
   - Required: reg9=0, pend_valid=0, commit_valid=0, and all registers are 0 immediately when rst_n falls (asynchronous).
